// File: rtl/sprite_pkg.sv
// Line-buffer entry layout and the read-modify-write merge rule shared by the sprite writer.
package sprite_pkg;

    localparam int LB_ENTRY_W   = 16;
    localparam int LB_COLOR_LSB = 0;
    localparam int LB_COLOR_MSB = 7;
    localparam int LB_Z_LSB     = 8;
    localparam int LB_Z_MSB     = 9;
    localparam int LB_MASK_LSB  = 10;
    localparam int LB_MASK_MSB  = 13;
    localparam int LB_RSVD_LSB  = 14;
    localparam int LB_RSVD_MSB  = 15;

    typedef struct packed {
        logic [1:0] rsvd;
        logic [3:0] mask;
        logic [1:0] z;
        logic [7:0] color;
    } lb_entry_t;

    typedef struct packed {
        logic [3:0]            collide;
        logic [LB_ENTRY_W-1:0] entry;
    } rmw_result_t;

    // Reserved bits are always written as zero.
    function automatic logic [LB_ENTRY_W-1:0] pack_entry(input logic [7:0] color,
                                                         input logic [1:0] z,
                                                         input logic [3:0] mask);
        logic [LB_ENTRY_W-1:0] e;
        e                            = '0;
        e[LB_COLOR_MSB:LB_COLOR_LSB] = color;
        e[LB_Z_MSB:LB_Z_LSB]         = z;
        e[LB_MASK_MSB:LB_MASK_LSB]   = mask;
        return e;
    endfunction

    function automatic lb_entry_t unpack_entry(input logic [LB_ENTRY_W-1:0] raw);
        lb_entry_t e;
        e.color = raw[LB_COLOR_MSB:LB_COLOR_LSB];
        e.z     = raw[LB_Z_MSB:LB_Z_LSB];
        e.mask  = raw[LB_MASK_MSB:LB_MASK_LSB];
        e.rsvd  = raw[LB_RSVD_MSB:LB_RSVD_LSB];
        return e;
    endfunction

    // New pixel takes the slot if it is empty or strictly in front; equal depth keeps the
    // earlier pixel. The collision mask is accumulated either way.
    function automatic rmw_result_t rmw_merge(input logic [7:0] old_color,
                                              input logic [1:0] old_z,
                                              input logic [3:0] old_mask,
                                              input logic [7:0] new_color,
                                              input logic [1:0] new_z,
                                              input logic [3:0] new_mask);
        rmw_result_t r;
        if (old_color == 8'd0 || new_z > old_z)
            r.entry = pack_entry(new_color, new_z, old_mask | new_mask);
        else
            r.entry = pack_entry(old_color, old_z, old_mask | new_mask);
        r.collide = old_mask & new_mask;
        return r;
    endfunction

endpackage

// File: rtl/sprite_line_writer.sv
// Pipelined read-modify-write of sprite pixels into the render half of the line buffer,
// with depth/transparency resolution, RAW forwarding and per-line collision accumulation.
module sprite_line_writer
    import sprite_pkg::*;
#(
    parameter int LINE_WIDTH = 640
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [9:0]  pix_x,
    input  logic [7:0]  pix_color,
    input  logic [1:0]  pix_z,
    input  logic [3:0]  pix_mask,
    input  logic        line_start,
    output logic [9:0]  lb_rd_idx,
    input  logic [15:0] lb_rd_data,
    output logic [9:0]  lb_wr_idx,
    output logic [15:0] lb_wr_data,
    output logic        lb_wr_en,
    output logic [3:0]  collision_line,
    output logic        busy
);

    logic        accept;
    logic        keep_s0;

    logic        s1_vld_q;
    logic        s1_keep_q;
    logic [9:0]  s1_x_q;
    logic [7:0]  s1_color_q;
    logic [1:0]  s1_z_q;
    logic [3:0]  s1_mask_q;

    // wr_* is the registered write being presented; wr2_* is the write issued one cycle
    // earlier, which the line buffer may not yet reflect in the data read for S1.
    logic        wr_vld_q;
    logic [9:0]  wr_idx_q;
    logic [15:0] wr_data_q;
    logic        wr2_vld_q;
    logic [9:0]  wr2_idx_q;
    logic [15:0] wr2_data_q;

    logic [3:0]  acc_q, acc_d;
    logic [3:0]  coll_q, coll_d;

    logic [15:0] old_raw;
    lb_entry_t   old_e;
    rmw_result_t merge;
    logic        s1_write;
    logic [3:0]  s1_collide;
    logic        unused_rsvd;

    assign pix_ready = ~rst;
    assign accept    = pix_valid & pix_ready;
    assign lb_rd_idx = rst ? 10'd0 : pix_x;
    assign keep_s0   = ({1'b0, pix_x} < 11'(LINE_WIDTH)) && (pix_color != 8'd0) && (pix_z != 2'd0);

    // Pick the newest copy of the slot: last registered write, then the one before, then RAM.
    always_comb begin
        old_raw = lb_rd_data;
        if (wr2_vld_q && wr2_idx_q == s1_x_q)
            old_raw = wr2_data_q;
        if (wr_vld_q && wr_idx_q == s1_x_q)
            old_raw = wr_data_q;
    end

    assign old_e       = unpack_entry(old_raw);
    assign unused_rsvd = ^old_e.rsvd;
    assign merge       = rmw_merge(old_e.color, old_e.z, old_e.mask,
                                   s1_color_q, s1_z_q, s1_mask_q);
    assign s1_write    = s1_vld_q & s1_keep_q;
    assign s1_collide  = s1_write ? merge.collide : 4'd0;

    // A pixel finishing S1 during line_start still belongs to the line being closed.
    always_comb begin
        acc_d  = acc_q | s1_collide;
        coll_d = coll_q;
        if (line_start) begin
            coll_d = acc_q | s1_collide;
            acc_d  = 4'd0;
        end
    end

    // Pipeline stages, write registers and collision state.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q   <= 1'b0;
            s1_keep_q  <= 1'b0;
            s1_x_q     <= '0;
            s1_color_q <= '0;
            s1_z_q     <= '0;
            s1_mask_q  <= '0;
            wr_vld_q   <= 1'b0;
            wr_idx_q   <= '0;
            wr_data_q  <= '0;
            wr2_vld_q  <= 1'b0;
            wr2_idx_q  <= '0;
            wr2_data_q <= '0;
            acc_q      <= '0;
            coll_q     <= '0;
        end else begin
            s1_vld_q   <= accept;
            s1_keep_q  <= accept & keep_s0;
            s1_x_q     <= pix_x;
            s1_color_q <= pix_color;
            s1_z_q     <= pix_z;
            s1_mask_q  <= pix_mask;
            wr_vld_q   <= s1_write;
            if (s1_write) begin
                wr_idx_q  <= s1_x_q;
                wr_data_q <= merge.entry;
            end
            wr2_vld_q  <= wr_vld_q;
            wr2_idx_q  <= wr_idx_q;
            wr2_data_q <= wr_data_q;
            acc_q      <= acc_d;
            coll_q     <= coll_d;
        end
    end

    assign lb_wr_en       = wr_vld_q & ~rst;
    assign lb_wr_idx      = wr_idx_q;
    assign lb_wr_data     = wr_data_q;
    assign collision_line = coll_q;
    assign busy           = (s1_vld_q | wr_vld_q) & ~rst;

endmodule

// File: tb/tb_sprite_line_writer.sv
// Bench for sprite_line_writer: directed cases with literal expectations, then randomized
// traffic checked every cycle against a sequential (non-pipelined) model of the line buffer.
module tb_sprite_line_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_valid;
    logic        pix_ready;
    logic [9:0]  pix_x;
    logic [7:0]  pix_color;
    logic [1:0]  pix_z;
    logic [3:0]  pix_mask;
    logic        line_start;
    logic [9:0]  lb_rd_idx;
    logic [15:0] lb_rd_data;
    logic [9:0]  lb_wr_idx;
    logic [15:0] lb_wr_data;
    logic        lb_wr_en;
    logic [3:0]  collision_line;
    logic        busy;
    logic        mem_clr;

    sprite_line_writer dut (
        .clk            (clk),
        .rst            (rst),
        .pix_valid      (pix_valid),
        .pix_ready      (pix_ready),
        .pix_x          (pix_x),
        .pix_color      (pix_color),
        .pix_z          (pix_z),
        .pix_mask       (pix_mask),
        .line_start     (line_start),
        .lb_rd_idx      (lb_rd_idx),
        .lb_rd_data     (lb_rd_data),
        .lb_wr_idx      (lb_wr_idx),
        .lb_wr_data     (lb_wr_data),
        .lb_wr_en       (lb_wr_en),
        .collision_line (collision_line),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Line buffer RAM: registered read returning the pre-write value on a same-edge collision.
    logic [15:0] lb_mem [0:1023];
    always @(posedge clk) begin
        lb_rd_data <= lb_mem[lb_rd_idx];
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) lb_mem[i] <= 16'd0;
        end else if (lb_wr_en) begin
            lb_mem[lb_wr_idx] <= lb_wr_data;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] c;
        logic [1:0] z;
        logic [3:0] m;
    } px_t;
    typedef struct {
        int          due;
        logic [9:0]  idx;
        logic [15:0] data;
    } wexp_t;
    typedef struct {
        int         due;
        logic [3:0] val;
    } cexp_t;

    px_t   ref_mem [0:639];
    wexp_t wq[$];
    cexp_t cq[$];
    bit    accepted [0:8191];
    logic [3:0] acc_m = 4'd0;
    logic [3:0] exp_coll = 4'd0;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    int          wr_count = 0;
    logic [9:0]  last_wr_idx;
    logic [15:0] last_wr_data;
    int          last_wr_cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Drive one cycle of inputs and advance the sequential model; pixels are applied to the
    // model in acceptance order, so the pipeline must be indistinguishable from it.
    task automatic step(input logic v, input logic [9:0] x, input logic [7:0] c,
                        input logic [1:0] z, input logic [3:0] m, input logic ls, input logic r);
        int  k;
        px_t o;
        px_t n;
        k          = cyc;
        rst        = r;
        mem_clr    = r;
        pix_valid  = v;
        pix_x      = x;
        pix_color  = c;
        pix_z      = z;
        pix_mask   = m;
        line_start = ls;
        if (r) begin
            wq.delete();
            cq.push_back('{k + 1, 4'd0});
            acc_m = 4'd0;
            for (int i = 0; i < 640; i++) ref_mem[i] = '{8'd0, 2'd0, 4'd0};
        end else begin
            if (ls) begin
                cq.push_back('{k + 1, acc_m});
                acc_m = 4'd0;
            end
            if (v) begin
                accepted[k] = 1'b1;
                if (x < 10'd640 && c != 8'd0 && z != 2'd0) begin
                    o     = ref_mem[x];
                    n.m   = o.m | m;
                    acc_m = acc_m | (o.m & m);
                    if (o.c == 8'd0 || z > o.z) begin
                        n.c = c;
                        n.z = z;
                    end else begin
                        n.c = o.c;
                        n.z = o.z;
                    end
                    ref_mem[x] = n;
                    wq.push_back('{k + 2, x,
                                   16'(n.c) + 16'(n.z) * 16'd256 + 16'(n.m) * 16'd1024});
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 10'd0, 8'd0, 2'd0, 4'd0, 1'b0, 1'b0);
    endtask

    // Per-cycle comparison of every output against the model's expectations.
    logic exp_en;
    always @(negedge clk) begin
        if (chk_en) begin
            while (cq.size() > 0 && cq[0].due <= cyc) begin
                exp_coll = cq[0].val;
                void'(cq.pop_front());
            end
            exp_en = (wq.size() > 0 && wq[0].due == cyc);
            chk("wr_en", 32'(lb_wr_en), 32'(exp_en));
            if (exp_en) begin
                chk("wr_idx", 32'(lb_wr_idx), 32'(wq[0].idx));
                chk("wr_data", 32'(lb_wr_data), 32'(wq[0].data));
                void'(wq.pop_front());
            end
            chk("busy", 32'(busy), 32'(!rst && ((cyc > 0 && accepted[cyc - 1]) || exp_en)));
            chk("pix_ready", 32'(pix_ready), 32'(!rst));
            chk("rd_idx", 32'(lb_rd_idx), 32'(rst ? 10'd0 : pix_x));
            chk("collision_line", 32'(collision_line), 32'(exp_coll));
        end
        if (lb_wr_en === 1'b1) begin
            wr_count++;
            last_wr_idx  = lb_wr_idx;
            last_wr_data = lb_wr_data;
            last_wr_cyc  = cyc;
        end
    end

    logic       rv, rls, rr;
    logic [9:0] rx;
    logic [7:0] rc;
    logic [1:0] rz;
    logic [3:0] rm;
    int         kk, wc, mism;

    initial begin
        rst = 1'b1; mem_clr = 1'b1; pix_valid = 1'b0; pix_x = '0; pix_color = '0;
        pix_z = '0; pix_mask = '0; line_start = 1'b0;
        step(1'b0, 10'd0, 8'd0, 2'd0, 4'd0, 1'b0, 1'b1);
        chk_en = 1'b1;
        step(1'b0, 10'd0, 8'd0, 2'd0, 4'd0, 1'b0, 1'b1);
        idle(1);
        chk("reset_wr_idx", 32'(lb_wr_idx), 32'd0);
        chk("reset_wr_data", 32'(lb_wr_data), 32'd0);
        chk("reset_coll", 32'(collision_line), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);

        // single opaque pixel into an empty buffer
        kk = cyc;
        step(1'b1, 10'd5, 8'h12, 2'd2, 4'h1, 1'b0, 1'b0);
        idle(3);
        chk("t1_latency", 32'(last_wr_cyc), 32'(kk + 2));
        chk("t1_idx", 32'(last_wr_idx), 32'd5);
        chk("t1_data", 32'(last_wr_data), 32'h0612);

        // back-to-back same x, second in front
        step(1'b1, 10'd10, 8'h20, 2'd1, 4'h1, 1'b0, 1'b0);
        step(1'b1, 10'd10, 8'h30, 2'd3, 4'h2, 1'b0, 1'b0);
        idle(3);
        chk("t2_data", 32'(last_wr_data), 32'h0F30);
        step(1'b0, 10'd0, 8'd0, 2'd0, 4'd0, 1'b1, 1'b0);
        chk("t2_coll", 32'(collision_line), 32'h0);

        // equal depth: first pixel wins, masks collide
        step(1'b1, 10'd20, 8'h40, 2'd2, 4'h4, 1'b0, 1'b0);
        step(1'b1, 10'd20, 8'h50, 2'd2, 4'h4, 1'b0, 1'b0);
        idle(3);
        chk("t3_data", 32'(last_wr_data), 32'h1240);
        step(1'b0, 10'd0, 8'd0, 2'd0, 4'd0, 1'b1, 1'b0);
        chk("t3_coll", 32'(collision_line), 32'h4);

        // discarded pixels: transparent and off the end of the line
        wc = wr_count;
        step(1'b1, 10'd7, 8'h00, 2'd2, 4'h1, 1'b0, 1'b0);
        step(1'b1, 10'd640, 8'h05, 2'd2, 4'h1, 1'b0, 1'b0);
        idle(3);
        chk("t4_no_write", 32'(wr_count), 32'(wc));
        chk("t4_ready", 32'(pix_ready), 32'd1);

        // line_start coincides with the S1 cycle of a colliding pixel
        step(1'b1, 10'd30, 8'h11, 2'd1, 4'h2, 1'b0, 1'b0);
        step(1'b1, 10'd30, 8'h22, 2'd1, 4'h2, 1'b0, 1'b0);
        step(1'b0, 10'd0, 8'd0, 2'd0, 4'd0, 1'b1, 1'b0);
        chk("t5_coll", 32'(collision_line), 32'h2);
        idle(2);
        chk("t5_data", 32'(last_wr_data), 32'h0911);
        step(1'b0, 10'd0, 8'd0, 2'd0, 4'd0, 1'b1, 1'b0);
        chk("t5_coll_next", 32'(collision_line), 32'h0);

        // reset with pixels in flight
        step(1'b1, 10'd50, 8'h33, 2'd1, 4'h8, 1'b0, 1'b0);
        idle(2);
        step(1'b1, 10'd50, 8'h44, 2'd2, 4'h8, 1'b0, 1'b0);
        idle(3);
        step(1'b0, 10'd0, 8'd0, 2'd0, 4'd0, 1'b1, 1'b0);
        chk("t6_coll_before", 32'(collision_line), 32'h8);
        wc = wr_count;
        step(1'b1, 10'd60, 8'h05, 2'd1, 4'h1, 1'b0, 1'b0);
        step(1'b1, 10'd61, 8'h06, 2'd1, 4'h1, 1'b0, 1'b0);
        step(1'b0, 10'd0, 8'd0, 2'd0, 4'd0, 1'b0, 1'b1);
        chk("t6_coll_after", 32'(collision_line), 32'h0);
        chk("t6_busy", 32'(busy), 32'd0);
        idle(4);
        chk("t6_no_write", 32'(wr_count), 32'(wc));

        // randomized traffic, heavy on repeated positions
        for (int i = 0; i < 3000; i++) begin
            rv  = ($urandom_range(0, 3) != 0);
            rx  = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(630, 1023))
                                              : 10'($urandom_range(0, 7));
            rc  = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            rz  = 2'($urandom_range(0, 3));
            rm  = 4'($urandom_range(0, 15));
            rls = ($urandom_range(0, 39) == 0);
            rr  = ($urandom_range(0, 799) == 0);
            step(rv, rx, rc, rz, rm, rls, rr);
        end
        idle(4);

        mism = 0;
        for (int i = 0; i < 640; i++) begin
            if (lb_mem[i] !== 16'(ref_mem[i].c) + 16'(ref_mem[i].z) * 16'd256
                              + 16'(ref_mem[i].m) * 16'd1024)
                mism++;
        end
        chk("mem_final", 32'(mism), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
